// File: rtl/ohs_boost_seq.sv
// ohs_boost_seq: run-time sequencer for the level-2 boost converter model.
// Produces the model step strobe (ce) from a programmable divider, the switch
// command (S1_pwm) from a PWM carrier counted in steps, and holds the plant
// coefficients behind a shadow/commit bank. In RUN a commit is deferred to the
// PWM period boundary, so a retune never tears a period.
//
// Ports:
//   aclk, reset           clock, async active-high reset
//   enable                level run request
//   cfg_valid/cfg_ready   config write handshake
//   cfg_addr, cfg_data    register address / write data
//   kL, kRL, kC, kR, vdc  active coefficients to the model
//   ce                    one-cycle model step strobe
//   S1_pwm                switch command, 1 = closed
//   period_start          ce of the first step of each PWM period
//   step_count            ce pulses since last entry to RUN
module ohs_boost_seq #(
  parameter int data_width = 32,
  parameter int cnt_width  = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_addr,
  input  logic [data_width-1:0] cfg_data,
  output logic [data_width-1:0] kL,
  output logic [data_width-1:0] kRL,
  output logic [data_width-1:0] kC,
  output logic [data_width-1:0] kR,
  output logic [data_width-1:0] vdc,
  output logic                  ce,
  output logic                  S1_pwm,
  output logic                  period_start,
  output logic [31:0]           step_count
);
  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);
  localparam int DIV  = 0;
  localparam int PER  = 1;
  localparam int DUTY = 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic [4:0][data_width-1:0] coef_sh_q, coef_act_q;
  logic [2:0][cnt_width-1:0]  cnt_sh_q, cnt_act_q;
  logic                       pending_q, alive_q;
  logic [cnt_width-1:0]       div_cnt_q, div_cnt_d, pwm_cnt_q, pwm_cnt_d;
  logic                       ce_q, ce_d, s1_q, s1_d;
  logic [31:0]                step_q, step_d;

  logic                       hs, boundary, commit;
  logic [cnt_width-1:0]       div_eff, per_eff, div_new, div_nx;

  // alive_q keeps cfg_ready low until the first edge after reset releases
  assign cfg_ready = alive_q & ~pending_q;
  assign hs        = cfg_valid & cfg_ready;

  assign div_eff = (cnt_act_q[DIV] == '0) ? CNT_ONE : cnt_act_q[DIV];
  assign per_eff = (cnt_act_q[PER] == '0) ? CNT_ONE : cnt_act_q[PER];
  assign div_new = (cnt_sh_q[DIV]  == '0) ? CNT_ONE : cnt_sh_q[DIV];

  // The boundary edge ends the ce cycle of the last step in the period
  assign boundary = (state_q == RUN) & ce_q & (pwm_cnt_q >= per_eff - CNT_ONE);
  assign commit   = pending_q & ((state_q == IDLE) | (enable & boundary));

  // On a commit edge the divider already runs on the incoming divisor, so the
  // next ce lands exactly div_eff(new) cycles after the boundary ce.
  assign div_nx = commit ? div_new : div_eff;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    step_d    = step_q;
    ce_d      = 1'b0;
    s1_d      = 1'b0;
    case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        pwm_cnt_d = '0;
        step_d    = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_d   = IDLE;
          div_cnt_d = '0;
          pwm_cnt_d = '0;
          step_d    = '0;
        end else begin
          ce_d      = (div_cnt_q >= div_nx - CNT_ONE);
          div_cnt_d = ce_d ? '0 : div_cnt_q + CNT_ONE;
          if (ce_q) pwm_cnt_d = boundary ? '0 : pwm_cnt_q + CNT_ONE;
          // pwm_cnt only moves at the end of a ce cycle, so this registered
          // compare holds one switch state for the whole following step
          s1_d   = (pwm_cnt_q < cnt_act_q[DUTY]);
          step_d = step_q + {31'd0, ce_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      coef_sh_q  <= '0;
      coef_act_q <= '0;
      cnt_sh_q   <= '0;
      cnt_act_q  <= '0;
      pending_q  <= 1'b0;
      alive_q    <= 1'b0;
      div_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      ce_q       <= 1'b0;
      s1_q       <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      ce_q      <= ce_d;
      s1_q      <= s1_d;
      step_q    <= step_d;
      if (commit) begin
        coef_act_q <= coef_sh_q;
        cnt_act_q  <= cnt_sh_q;
        pending_q  <= 1'b0;
      end
      // hs needs cfg_ready, so it never coincides with a commit
      if (hs) begin
        case (cfg_addr)
          4'd0: coef_sh_q[0]   <= cfg_data;
          4'd1: coef_sh_q[1]   <= cfg_data;
          4'd2: coef_sh_q[2]   <= cfg_data;
          4'd3: coef_sh_q[3]   <= cfg_data;
          4'd4: coef_sh_q[4]   <= cfg_data;
          4'd5: cnt_sh_q[DIV]  <= cfg_data[cnt_width-1:0];
          4'd6: cnt_sh_q[PER]  <= cfg_data[cnt_width-1:0];
          4'd7: cnt_sh_q[DUTY] <= cfg_data[cnt_width-1:0];
          4'd8: pending_q      <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign kL           = coef_act_q[0];
  assign kRL          = coef_act_q[1];
  assign kC           = coef_act_q[2];
  assign kR           = coef_act_q[3];
  assign vdc          = coef_act_q[4];
  assign ce           = ce_q;
  assign S1_pwm       = s1_q;
  assign period_start = ce_q & (pwm_cnt_q == '0);
  assign step_count   = step_q;

endmodule

// File: tb/tb_ohs_boost_seq.sv
// Bench for ohs_boost_seq: directed + randomized config/enable traffic. A
// schedule-level model predicts which cycles carry ce and what each step must
// show; predictions go into queues that a negedge monitor pops and compares.
module tb_ohs_boost_seq;
  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [31:0] kL, kRL, kC, kR, vdc;
  logic        ce, S1_pwm, period_start;
  logic [31:0] step_count;

  ohs_boost_seq #(.data_width(32), .cnt_width(16)) dut (
    .aclk(aclk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .kL(kL), .kRL(kRL), .kC(kC), .kR(kR), .vdc(vdc),
    .ce(ce), .S1_pwm(S1_pwm), .period_start(period_start),
    .step_count(step_count)
  );

  always #5 aclk = ~aclk;

  typedef struct { int cyc; bit ps; int unsigned steps; } ce_rec_t;
  typedef struct { int cyc; bit s1; } s1_rec_t;
  ce_rec_t q_ce[$];
  s1_rec_t q_s1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // reference model state: registers by address, plus a step schedule
  logic [31:0] m_sh [8];
  logic [31:0] m_act[8];
  bit          m_pend, m_alive, m_run, m_hs;
  int          m_next_ce;   // cycle index of the next ce pulse
  int          m_pos;       // carrier position of that next ce
  int unsigned m_steps;

  function automatic int eff(logic [31:0] v);
    return (v[15:0] == 16'd0) ? 1 : int'(v[15:0]);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    m_pend = 0; m_alive = 0; m_run = 0; m_hs = 0;
    m_next_ce = 0; m_pos = 0; m_steps = 0;
    q_ce.delete();
    q_s1.delete();
  endtask

  // Called at each rising edge; advances the model from cycle cyc to cyc+1.
  task automatic model_edge();
    int          c;
    bit          ce_now, bnd, com;
    logic [31:0] old_duty;
    ce_rec_t     r;
    s1_rec_t     s;
    c        = cyc;
    m_hs     = cfg_valid && m_alive && !m_pend;
    ce_now   = m_run && (m_next_ce == c);
    bnd      = ce_now && (m_pos == eff(m_act[6]) - 1);
    com      = m_pend && (!m_run || (enable && bnd));
    old_duty = m_act[7];
    cyc      = cyc + 1;
    m_alive  = 1;
    if (com) begin
      for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
      m_pend = 0;
    end
    if (m_hs) begin
      if (cfg_addr < 4'd5)      m_sh[cfg_addr[2:0]] = cfg_data;
      else if (cfg_addr < 4'd8) m_sh[cfg_addr[2:0]] = {16'h0, cfg_data[15:0]};
      else if (cfg_addr == 4'd8) m_pend = 1;
    end
    if (!m_run) begin
      if (enable) begin
        m_run     = 1;
        m_pos     = 0;
        m_steps   = 0;
        m_next_ce = c + 1 + eff(m_act[5]);
      end
    end else if (!enable) begin
      m_run = 0;
    end else if (ce_now) begin
      s.cyc = cyc;
      s.s1  = int'(old_duty[15:0]) > m_pos;
      q_s1.push_back(s);
      m_pos     = bnd ? 0 : m_pos + 1;
      m_next_ce = c + eff(m_act[5]);
    end
    if (m_run && m_next_ce == cyc) begin
      r.cyc   = cyc;
      r.ps    = (m_pos == 0);
      r.steps = m_steps + 1;
      m_steps = m_steps + 1;
      q_ce.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    model_edge();
    #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic cfg_write(logic [3:0] a, logic [31:0] d);
    bit done = 0;
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    for (int i = 0; i < 2000 && !done; i++) begin
      tick();
      done = m_hs;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL cfg_write_timeout: addr %0d not accepted within 2000 cycles", a);
    end
  endtask

  function automatic logic [31:0] rand_data(logic [3:0] a);
    logic [31:0] hi;
    hi = $urandom & 32'hFFFF_0000;
    case (a)
      4'd5:    return hi | $urandom_range(0, 5);
      4'd6:    return hi | $urandom_range(0, 12);
      4'd7:    return hi | $urandom_range(0, 14);
      default: return $urandom;
    endcase
  endfunction

  // monitor
  always @(negedge aclk) begin
    if (chk_en) begin
      bit      exp_ce;
      ce_rec_t r;
      check("cfg_ready", 64'(cfg_ready), 64'(m_alive && !m_pend));
      check("kL",  64'(kL),  64'(m_act[0]));
      check("kRL", 64'(kRL), 64'(m_act[1]));
      check("kC",  64'(kC),  64'(m_act[2]));
      check("kR",  64'(kR),  64'(m_act[3]));
      check("vdc", 64'(vdc), 64'(m_act[4]));
      if (!m_run) begin
        check("idle_s1",    64'(S1_pwm),     64'(0));
        check("idle_steps", 64'(step_count), 64'(0));
      end
      exp_ce = (q_ce.size() > 0) && (q_ce[0].cyc == cyc);
      check("ce", 64'(ce), 64'(exp_ce));
      if (exp_ce) begin
        r = q_ce.pop_front();
        check("period_start", 64'(period_start), 64'(r.ps));
        check("step_count",   64'(step_count),   64'(r.steps));
      end else begin
        check("period_start_off", 64'(period_start), 64'(0));
      end
      while (q_s1.size() > 0 && q_s1[0].cyc < cyc) void'(q_s1.pop_front());
      if (q_s1.size() > 0 && q_s1[0].cyc == cyc) begin
        check("S1_pwm", 64'(S1_pwm), 64'(q_s1[0].s1));
        void'(q_s1.pop_front());
      end
    end
  end

  initial begin
    int r;
    logic [3:0] a;
    model_reset();
    #12;
    check("rst_ready", 64'(cfg_ready),  64'(0));
    check("rst_ce",    64'(ce),         64'(0));
    check("rst_s1",    64'(S1_pwm),     64'(0));
    check("rst_ps",    64'(period_start), 64'(0));
    check("rst_steps", 64'(step_count), 64'(0));
    check("rst_kL",    64'(kL),         64'(0));
    check("rst_vdc",   64'(vdc),        64'(0));
    @(posedge aclk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();
    check("ready_after_reset", 64'(cfg_ready), 64'(1));

    // IDLE coefficient commit
    cfg_write(4'd0, 32'h0040_0000);
    cfg_write(4'd4, 32'h0C00_0000);
    cfg_write(4'd8, 32'h0);
    run(2);
    check("kL_commit",  64'(kL),  64'h0040_0000);
    check("vdc_commit", 64'(vdc), 64'h0C00_0000);

    // div 4, period 10, duty 3
    cfg_write(4'd5, 32'd4);
    cfg_write(4'd6, 32'd10);
    cfg_write(4'd7, 32'd3);
    cfg_write(4'd8, 32'h0);
    run(2);
    enable = 1'b1;
    tick();
    run(40);
    check("steps_after_40", 64'(step_count), 64'd10);
    run(7);

    // mid-period duty retune
    cfg_write(4'd7, 32'd7);
    cfg_write(4'd8, 32'h0);
    run(100);

    // corners
    cfg_write(4'd7, 32'd0);  cfg_write(4'd8, 32'h0); run(60);
    cfg_write(4'd7, 32'd12); cfg_write(4'd8, 32'h0); run(60);
    cfg_write(4'd5, 32'd0);  cfg_write(4'd8, 32'h0); run(30);

    // drop enable mid-period, then re-enter
    enable = 1'b0;
    tick();
    check("exit_ce",    64'(ce),         64'(0));
    check("exit_s1",    64'(S1_pwm),     64'(0));
    check("exit_steps", 64'(step_count), 64'(0));
    check("exit_kL",    64'(kL),         64'h0040_0000);
    run(3);
    enable = 1'b1;
    tick();
    check("reentry_steps", 64'(step_count), 64'(0));
    run(20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        enable = ~enable;
        tick();
      end else if (r < 15) begin
        a = 4'($urandom_range(0, 15));
        cfg_write(a, rand_data(a));
      end else if (r < 20) begin
        cfg_write(4'd8, $urandom);
      end else begin
        tick();
      end
    end

    // async reset between edges while running
    enable = 1'b1;
    run(25);
    chk_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("areset_ready", 64'(cfg_ready),    64'(0));
    check("areset_ce",    64'(ce),           64'(0));
    check("areset_s1",    64'(S1_pwm),       64'(0));
    check("areset_ps",    64'(period_start), 64'(0));
    check("areset_steps", 64'(step_count),   64'(0));
    check("areset_kL",    64'(kL),           64'(0));
    @(posedge aclk);
    #1;
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    run(30);
    enable = 1'b0;
    run(3);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ohs_boost_seq.md
# ohs_boost_seq

Run-time sequencer for the level-2 boost converter model. Generates the model's integration strobe `ce` and switch command `S1_pwm` from a programmable step divider and PWM carrier. Also holds the model coefficients `kL`, `kRL`, `kC`, `kR` and `vdc` behind a shadow/commit register bank, so a host can retune the plant without tearing a PWM period. Sits between the host configuration bus and the `ohs_boost` model instance; all model inputs come from this block.

## Interface

- `data_width`, 32, width of coefficients and config data.
- `cnt_width`, 16, width of the step divider, PWM period and duty fields.
- `aclk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run request, level-sensitive.
- `cfg_valid` in 1: config write request.
- `cfg_ready` out 1: config write accepted when high with `cfg_valid`.
- `cfg_addr` in 4: register address.
- `cfg_data` in `data_width`: write data, two's complement or unsigned per register.
- `kL`, `kRL`, `kC`, `kR`, `vdc` out `data_width` each: active coefficients to the model.
- `ce` out 1: one-cycle model step strobe.
- `S1_pwm` out 1: switch command, 1 = switch closed.
- `period_start` out 1: one-cycle pulse on the first step of each PWM period.
- `step_count` out 32: ce pulses since last entry to RUN, wraps modulo 2^32.

## Operation

- Register map (shadow):
  - 0 kL, 1 kRL, 2 kC, 3 kR, 4 vdc.
  - 5 ce_div, 6 pwm_period, 7 pwm_duty; these use the low `cnt_width` bits, unsigned.
  - 8 COMMIT; data is ignored.
  - 9–15 are accepted and discarded.
- A write to 0–7 updates the shadow on the accepting edge.
- A COMMIT write sets `pending`. While `pending`=1, `cfg_ready`=0.
- Commit copies all eight shadow registers to the active set and clears `pending`. When commit happens:
  - IDLE: on the edge after the COMMIT handshake.
  - RUN: on the period-boundary edge, i.e. the edge ending a `ce` cycle where `pwm_cnt`=`period_eff`-1.
- Effective values: `div_eff` = max(ce_div,1), `period_eff` = max(pwm_period,1). A duty of 0 or a duty ≥ `period_eff` needs no special handling: the compare below yields S1 never or always closed.
- FSM states:
  - IDLE: counters cleared, `ce`=0, `S1_pwm`=0.
  - RUN: counters active.
- FSM transitions:
  - IDLE→RUN on an edge with `enable`=1. That edge also performs any pending commit, and clears `div_cnt`, `pwm_cnt` and `step_count`.
  - RUN→IDLE on any edge with `enable`=0. All counters, `ce`, `S1_pwm` and `period_start` are zeroed on that edge. Active coefficients hold their values; `pending` holds and commits per the IDLE rule.
- Divider: in RUN, `div_cnt` counts 0..`div_eff`-1 and wraps. `ce` is registered, high for the cycle after `div_cnt`=`div_eff`-1.
- Carrier: `pwm_cnt` advances on each edge ending a `ce` cycle and wraps at `period_eff`-1.
  - `S1_pwm` is registered as (`pwm_cnt` < `pwm_duty`), unsigned compare.
  - `period_start` equals `ce` AND (`pwm_cnt`=0).
- Reset values:
  - Active and shadow coefficients are 0; ce_div, pwm_period and pwm_duty are 0, so their effective values are 1.
  - `pending`=0, state IDLE.
  - All outputs are 0, including `cfg_ready` while `reset` is high.
  - `cfg_ready`=1 from the first edge after `reset` deasserts.

## Timing

- First `ce` comes `div_eff` cycles after the IDLE→RUN edge. Later `ce` pulses come every `div_eff` cycles. With `div_eff`=1, `ce` is high every cycle.
- `S1_pwm` reflects the new `pwm_cnt` one cycle after the `ce` that advanced it. The model sees a stable switch state for the whole step.
- The first `S1_pwm` value after the RUN entry edge is valid on the next cycle, using `pwm_cnt`=0.
- Commit latency in RUN is ≤ `div_eff`·`period_eff` cycles.
  - New coefficients, `div_eff` and `period_eff` take effect on the commit edge; new duty on the next `S1_pwm` update.
  - `cfg_ready` returns to 1 the cycle after commit.
- If a COMMIT handshake and a period boundary occur on the same edge, `pending` is set and that boundary does not commit. Commit happens at the next boundary.
- Asynchronous `reset` mid-period aborts immediately. Outputs go to reset values with no clock required.

## Test plan

- Reset → all outputs 0, `cfg_ready`=1 one edge after deassert; `kL`..`vdc` = 0.
- IDLE write kL=0x0040_0000, vdc=0x0C00_0000, COMMIT → `cfg_ready` low one cycle; outputs update on the next edge.
- ce_div=4, pwm_period=10, pwm_duty=3, commit, enable=1 →
  - `ce` every 4 cycles, first on cycle 4;
  - `S1_pwm` high 3 steps of 10;
  - `period_start` every 40 cycles;
  - `step_count`=10 after 40 cycles.
- RUN, write duty=7 then COMMIT mid-period → `cfg_ready`=0 until the boundary edge; the next period has 7 high steps; the current period is unchanged.
- Corner values:
  - duty=0 → `S1_pwm` constantly 0;
  - duty=12 with period=10 → constantly 1;
  - ce_div=0 → `ce` every cycle.
- enable low mid-period → next edge `ce`, `S1_pwm` and counters are 0, coefficients hold. Re-enable → `step_count` restarts at 0. Asserting `reset` between edges → outputs 0 before the next edge.
